gemm_array_ctrl: RTL and testbench

Sequencer for the N x N systolic GEMM array built from the signed MAC processing elements.
- Accepts a job of inner dimension K.
- Issues one accumulator-clear pulse to the array.
- Drives per-lane skewed operand read enables and indices for the A-row and B-column buffers.
- Waits out the array fill latency, then drains the N result rows over a valid/ready handshake.
- Sits between the host command interface and the operand buffers / array.

---
 rtl/gemm_pkg.sv | 25 ++
 rtl/gemm_skew_gen.sv | 24 ++
 rtl/gemm_array_ctrl.sv | 175 +++++++++++++++++
 tb/tb_gemm_array_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and constants for the systolic GEMM array sequencer.
// Also used by the testbench.
package gemm_pkg;

   localparam int N_DEF     = 4;
   localparam int K_MAX_DEF = 256;
   localparam int KW_DEF    = $clog2(K_MAX_DEF + 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      FLUSH,
      DRAIN,
      DONE
   } state_e;

   // Skewed feed: lane N-1 starts N-1 cycles late, so it finishes k+N-1 cycles after lane 0 starts.
   function automatic int feed_len(input int k, input int n);
      return k + n - 1;
   endfunction

   localparam int FEED_LEN_MAX_DEF = feed_len(K_MAX_DEF, N_DEF);

endpackage

// File: rtl/gemm_skew_gen.sv
// Per-lane skewed operand read enables and k indices for a feed step t.
// Lane i is active for t in [i, i+k_len).
module gemm_skew_gen #(
   parameter int N  = 4,
   parameter int KW = 9,
   parameter int TW = 10
) (
   input  logic [TW-1:0]   t_i,
   input  logic [KW-1:0]   k_len_i,
   output logic [N-1:0]    rd_en_o,
   output logic [N*KW-1:0] rd_k_o
);

   for (genvar i = 0; i < N; i++) begin : g_lane
      localparam logic [TW-1:0] LANE = TW'(i);
      logic lane_en;

      // The subtraction is only meaningful once t has reached the lane offset.
      assign lane_en = (t_i >= LANE) && ((t_i - LANE) < TW'(k_len_i));
      assign rd_en_o[i] = lane_en;
      assign rd_k_o[i*KW +: KW] = lane_en ? KW'(t_i - LANE) : '0;
   end

endmodule

// File: rtl/gemm_array_ctrl.sv
// Job sequencer for the N x N systolic GEMM array: clear, skewed feed,
// flush, then drain of N result rows over valid/ready.
module gemm_array_ctrl
   import gemm_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int K_MAX     = K_MAX_DEF,
   parameter int KW        = $clog2(K_MAX + 1),
   parameter int FLUSH_CYC = N
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [KW-1:0]        k_len,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 array_clear,
   output logic [N-1:0]         rd_en,
   output logic [N*KW-1:0]      rd_k,
   output logic                 res_valid,
   output logic [$clog2(N)-1:0] res_row,
   input  logic                 res_ready
);

   // t must reach K_MAX+N-2 without wrapping.
   localparam int TW  = $clog2(K_MAX + N - 1);
   localparam int RW  = $clog2(N);
   localparam int FCW = $clog2(FLUSH_CYC + 1);

   state_e          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [TW-1:0]   t_q, t_d;
   logic [FCW-1:0]  fc_q, fc_d;
   logic [RW-1:0]   row_q, row_d;

   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            clear_q, clear_d;
   logic [N-1:0]    rd_en_q, rd_en_d;
   logic [N*KW-1:0] rd_k_q, rd_k_d;
   logic            res_valid_q, res_valid_d;
   logic [RW-1:0]   res_row_q, res_row_d;

   logic [TW-1:0]   t_last;
   logic            k_ok;
   logic [N-1:0]    skew_en;
   logic [N*KW-1:0] skew_k;

   assign t_last = TW'(feed_len(int'(k_q), N) - 1);
   assign k_ok   = (k_len != '0) && (k_len <= KW'(K_MAX));

   // Fed with next-state values so the registered enables line up with the FEED cycle they belong to.
   gemm_skew_gen #(
      .N  (N),
      .KW (KW),
      .TW (TW)
   ) u_skew (
      .t_i     (t_d),
      .k_len_i (k_d),
      .rd_en_o (skew_en),
      .rd_k_o  (skew_k)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q     <= IDLE;
         k_q         <= '0;
         t_q         <= '0;
         fc_q        <= '0;
         row_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         clear_q     <= 1'b0;
         rd_en_q     <= '0;
         rd_k_q      <= '0;
         res_valid_q <= 1'b0;
         res_row_q   <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         t_q         <= t_d;
         fc_q        <= fc_d;
         row_q       <= row_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         clear_q     <= clear_d;
         rd_en_q     <= rd_en_d;
         rd_k_q      <= rd_k_d;
         res_valid_q <= res_valid_d;
         res_row_q   <= res_row_d;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first, so no path through the case can infer a latch.
      state_d = state_q;
      k_d     = k_q;
      t_d     = t_q;
      fc_d    = fc_q;
      row_d   = row_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (k_ok) begin
                  k_d     = k_len;
                  state_d = CLEAR;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CLEAR: begin
            t_d     = '0;
            state_d = FEED;
         end
         FEED: begin
            if (t_q == t_last) begin
               fc_d    = '0;
               state_d = FLUSH;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         FLUSH: begin
            if (fc_q == FCW'(FLUSH_CYC - 1)) begin
               row_d   = '0;
               state_d = DRAIN;
            end else begin
               fc_d = fc_q + FCW'(1);
            end
         end
         DRAIN: begin
            if (res_valid_q && res_ready) begin
               if (row_q == RW'(N - 1)) begin
                  state_d = DONE;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      clear_d     = (state_d == CLEAR);
      res_valid_d = (state_d == DRAIN);
      res_row_d   = res_valid_d ? row_d : '0;
      rd_en_d     = '0;
      rd_k_d      = '0;
      if (state_d == FEED) begin
         rd_en_d = skew_en;
         rd_k_d  = skew_k;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign array_clear = clear_q;
   assign rd_en       = rd_en_q;
   assign rd_k        = rd_k_q;
   assign res_valid   = res_valid_q;
   assign res_row     = res_row_q;

endmodule

// File: tb/tb_gemm_array_ctrl.sv
// Directed self-checking bench for gemm_array_ctrl (N=4, K_MAX=256).
module tb_gemm_array_ctrl;
   import gemm_pkg::*;

   localparam int N         = 4;
   localparam int K_MAX     = 256;
   localparam int KW        = $clog2(K_MAX + 1);
   localparam int FLUSH_CYC = N;
   localparam int RW        = $clog2(N);

   logic            clk;
   logic            reset;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            done;
   logic            err;
   logic            array_clear;
   logic [N-1:0]    rd_en;
   logic [N*KW-1:0] rd_k;
   logic            res_valid;
   logic [RW-1:0]   res_row;
   logic            res_ready;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   gemm_array_ctrl #(
      .N         (N),
      .K_MAX     (K_MAX),
      .KW        (KW),
      .FLUSH_CYC (FLUSH_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .k_len       (k_len),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .array_clear (array_clear),
      .rd_en       (rd_en),
      .rd_k        (rd_k),
      .res_valid   (res_valid),
      .res_row     (res_row),
      .res_ready   (res_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [KW-1:0] lane_k(input int i);
      return rd_k[i*KW +: KW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!done && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_err"},   err, 0);
      check({tag, "_clear"}, array_clear, 0);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_k"},  rd_k, 0);
      check({tag, "_valid"}, res_valid, 0);
      check({tag, "_row"},   res_row, 0);
   endtask

   // Hand-derived expectations for k_len=3, FEED t=0..5.
   logic [N-1:0] en_tab1 [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
   int           k0_tab1 [6] = '{0, 1, 2, 0, 0, 0};
   int           k3_tab1 [6] = '{0, 0, 0, 0, 1, 2};
   logic         rdy_tab [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   int           row_tab [7] = '{0, 0, 0, 1, 1, 2, 3};

   initial begin
      int cyc;
      int clears;
      int errs;
      int done_seen;
      logic [N-1:0] onehot;

      reset     = 1'b1;
      start     = 1'b0;
      k_len     = '0;
      res_ready = 1'b1;
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
      check_all_zero("post_reset");

      // Basic job, k_len=3
      k_len = 3;
      start = 1'b1;
      check("t1_busy_c0", busy, 0);
      tick();
      start = 1'b0;
      check("t1_clear_c1", array_clear, 1);
      check("t1_busy_c1", busy, 1);
      check("t1_en_c1", rd_en, 0);
      for (int c = 0; c < 6; c++) begin
         tick();
         check("t1_feed_en", rd_en, en_tab1[c]);
         check("t1_feed_k0", lane_k(0), k0_tab1[c]);
         check("t1_feed_k3", lane_k(3), k3_tab1[c]);
         check("t1_feed_clear", array_clear, 0);
      end
      for (int c = 0; c < FLUSH_CYC; c++) begin
         tick();
         check("t1_flush_en", rd_en, 0);
         check("t1_flush_valid", res_valid, 0);
         check("t1_flush_busy", busy, 1);
      end
      for (int r = 0; r < N; r++) begin
         tick();
         check("t1_drain_valid", res_valid, 1);
         check("t1_drain_row", res_row, r);
         check("t1_drain_done", done, 0);
      end
      tick();
      check("t1_done", done, 1);
      check("t1_done_busy", busy, 1);
      check("t1_done_valid", res_valid, 0);
      tick();
      check("t1_idle_done", done, 0);
      check("t1_idle_busy", busy, 0);

      // Rejected starts
      k_len = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t2_err_k0", err, 1);
      check("t2_busy_k0", busy, 0);
      check("t2_clear_k0", array_clear, 0);
      tick();
      check("t2_err_drop0", err, 0);
      k_len = KW'(K_MAX + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t2_err_kbig", err, 1);
      check("t2_busy_kbig", busy, 0);
      tick();
      check("t2_err_drop1", err, 0);
      check("t2_clear_kbig", array_clear, 0);
      check("t2_busy_after", busy, 0);

      // k_len=1: one-hot walk, all indices zero
      k_len = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t3_clear", array_clear, 1);
      onehot = 4'b0001;
      for (int c = 0; c < N; c++) begin
         tick();
         check("t3_onehot", rd_en, onehot);
         check("t3_rd_k", rd_k, 0);
         onehot = onehot << 1;
      end
      wait_done(64, cyc);
      check("t3_done", done, 1);
      check("t3_done_latency", cyc, 9);
      tick();

      // Back-pressured drain
      res_ready = 1'b0;
      k_len = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 64 && !res_valid; n++) tick();
      check("t4_valid", res_valid, 1);
      for (int c = 0; c < 7; c++) begin
         res_ready = rdy_tab[c];
         check("t4_row", res_row, row_tab[c]);
         check("t4_hold_valid", res_valid, 1);
         check("t4_no_done", done, 0);
         tick();
      end
      check("t4_done", done, 1);
      res_ready = 1'b1;
      tick();
      check("t4_done_drop", done, 0);

      // Reset in the middle of FEED
      k_len = 3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("t5_feed_t2", rd_en, 4'b0111);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("t5_reset");
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done) done_seen++;
      end
      check("t5_no_done", done_seen, 0);
      check("t5_idle_busy", busy, 0);
      k_len = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t5_restart_clear", array_clear, 1);
      wait_done(64, cyc);
      check("t5_restart_done", done, 1);
      check("t5_restart_latency", cyc, 14);
      tick();

      // start held high across a whole job
      k_len = 1;
      start = 1'b1;
      tick();
      clears = int'(array_clear);
      errs   = int'(err);
      for (int c = 2; c <= 14; c++) begin
         tick();
         clears += int'(array_clear);
         errs   += int'(err);
      end
      check("t6_done_c14", done, 1);
      check("t6_one_clear", clears, 1);
      check("t6_no_err", errs, 0);
      tick();
      check("t6_idle_busy", busy, 0);
      check("t6_idle_clear", array_clear, 0);
      check("t6_idle_err", err, 0);
      tick();
      check("t6_second_clear", array_clear, 1);
      check("t6_second_busy", busy, 1);
      start = 1'b0;
      wait_done(64, cyc);
      check("t6_second_done", done, 1);
      check("t6_second_latency", cyc, 13);
      tick();

      // k_len=K_MAX: last lane ends on index K_MAX-1
      k_len = KW'(K_MAX);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (K_MAX + N - 1) tick();
      check("t7_last_en", rd_en, 4'b1000);
      check("t7_last_k3", lane_k(3), K_MAX - 1);
      tick();
      check("t7_flush_en", rd_en, 0);
      wait_done(64, cyc);
      check("t7_done", done, 1);
      check("t7_done_latency", cyc, 8);
      tick();
      check("t7_idle_busy", busy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
